// File: rtl/ad_ip_jesd204_tpl_dac_stream.sv
// Streaming DMA front-end for the JESD204 TPL DAC: elastic FIFO, armed/triggered start,
// link_ready back-pressure, registered channel crossbar and underflow accounting.
module ad_ip_jesd204_tpl_dac_stream #(
  parameter int NUM_CHANNELS    = 2,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PRIME_LEVEL     = 4,
  parameter int XBAR_ENABLE     = 1
) (
  input  logic                                                    clk_i,
  input  logic                                                    reset_i,
  input  logic                                                    s_valid_i,
  output logic                                                    s_ready_o,
  input  logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE*NUM_CHANNELS-1:0] s_data_i,
  output logic                                                    link_valid_o,
  input  logic                                                    link_ready_i,
  output logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE*NUM_CHANNELS-1:0] link_data_o,
  input  logic                                                    dac_sync_i,
  input  logic                                                    dac_sync_in_i,
  input  logic                                                    ext_sync_en_i,
  input  logic [15:0]                                             sync_timeout_i,
  input  logic [NUM_CHANNELS-1:0]                                 dac_enable_i,
  input  logic [8*NUM_CHANNELS-1:0]                               dac_src_chan_sel_i,
  input  logic                                                    underflow_clr_i,
  output logic                                                    sync_armed_o,
  output logic                                                    sync_timeout_err_o,
  output logic [15:0]                                             underflow_count_o,
  output logic [FIFO_ADDR_WIDTH:0]                                fifo_level_o
);

  localparam int CW    = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
  localparam int DW    = CW * NUM_CHANNELS;
  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_THR = (PRIME_LEVEL > DEPTH) ? DEPTH_LVL : LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t          state_q, state_d;
  logic            syncD1_q, syncInD1_q;
  logic            syncRise, syncInRise;
  logic [15:0]     timeoutCnt_q, timeoutCnt_d;
  logic            timeoutErr_q, errSet;

  logic [DW-1:0]   fifoMem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q, rdPtr_q;
  logic [LW-1:0]   level_q;
  logic            push, pop, starve, fifoEmpty, runState;
  logic [DW-1:0]   fifoHead, xbarData;
  logic [7:0]      srcSel;

  logic [DW-1:0]   linkData_q;
  logic            linkValid_q;
  logic [15:0]     underflowCnt_q;

  assign syncRise   = dac_sync_i & ~syncD1_q;
  assign syncInRise = dac_sync_in_i & ~syncInD1_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      syncD1_q   <= 1'b0;
      syncInD1_q <= 1'b0;
    end else begin
      syncD1_q   <= dac_sync_i;
      syncInD1_q <= dac_sync_in_i;
    end
  end

  // A software sync rise overrides both the trigger and the timeout, from any state.
  always_comb begin
    state_d      = state_q;
    timeoutCnt_d = timeoutCnt_q;
    errSet       = 1'b0;
    case (state_q)
      ST_ARMED: begin
        timeoutCnt_d = timeoutCnt_q + 16'd1;
        if (syncInRise) begin
          state_d = ST_PRIME;
        end else if ((sync_timeout_i != 16'd0) && (timeoutCnt_q == sync_timeout_i - 16'd1)) begin
          state_d = ST_IDLE;
          errSet  = 1'b1;
        end
      end
      ST_PRIME: begin
        if (level_q >= PRIME_THR) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    if (syncRise) begin
      state_d      = ext_sync_en_i ? ST_ARMED : ST_PRIME;
      timeoutCnt_d = 16'd0;
      errSet       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      timeoutCnt_q <= 16'd0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timeoutCnt_q <= timeoutCnt_d;
      if (underflow_clr_i) begin
        timeoutErr_q <= 1'b0;
      end else if (errSet) begin
        timeoutErr_q <= 1'b1;
      end
    end
  end

  assign runState  = (state_q == ST_RUN);
  assign fifoEmpty = (level_q == '0);
  assign s_ready_o = ~reset_i & (level_q < DEPTH_LVL);
  assign push      = s_valid_i & s_ready_o;
  assign pop       = link_ready_i & runState & ~fifoEmpty;
  assign starve    = link_ready_i & runState & fifoEmpty;
  assign fifoHead  = fifoMem_q[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= s_data_i;
    end
  end

  // Occupancy decides full/empty; pointers simply wrap modulo the depth.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    xbarData = '0;
    srcSel   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      srcSel = (XBAR_ENABLE != 0) ? dac_src_chan_sel_i[8*i +: 8] : 8'(i);
      if (dac_enable_i[i] && (int'(srcSel) < NUM_CHANNELS)) begin
        xbarData[CW*i +: CW] = fifoHead[CW*int'(srcSel) +: CW];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      linkData_q     <= '0;
      linkValid_q    <= 1'b0;
      underflowCnt_q <= 16'd0;
    end else begin
      linkValid_q <= 1'b1;
      if (link_ready_i) begin
        linkData_q <= pop ? xbarData : '0;
      end
      if (underflow_clr_i) begin
        underflowCnt_q <= 16'd0;
      end else if (starve && (underflowCnt_q != 16'hFFFF)) begin
        underflowCnt_q <= underflowCnt_q + 16'd1;
      end
    end
  end

  assign link_data_o        = linkData_q;
  assign link_valid_o       = linkValid_q;
  assign sync_armed_o       = (state_q == ST_ARMED);
  assign sync_timeout_err_o = timeoutErr_q;
  assign underflow_count_o  = underflowCnt_q;
  assign fifo_level_o       = level_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_stream.sv
// Directed self-checking bench for ad_ip_jesd204_tpl_dac_stream (4 channels, 16-deep FIFO).
module tb_ad_ip_jesd204_tpl_dac_stream;

  localparam int NCH = 4;
  localparam int CW  = 64;
  localparam int DW  = CW * NCH;

  logic             clk = 1'b0;
  logic             reset, s_valid, s_ready, link_valid, link_ready;
  logic             dac_sync, dac_sync_in, ext_sync_en, underflow_clr;
  logic             sync_armed, sync_timeout_err;
  logic [DW-1:0]    s_data, link_data;
  logic [15:0]      sync_timeout, underflow_count;
  logic [NCH-1:0]   dac_enable;
  logic [8*NCH-1:0] sel;
  logic [4:0]       fifo_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_stream #(
    .NUM_CHANNELS(NCH), .DATA_PATH_WIDTH(4), .BITS_PER_SAMPLE(16),
    .FIFO_ADDR_WIDTH(4), .PRIME_LEVEL(4), .XBAR_ENABLE(1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .link_valid_o(link_valid), .link_ready_i(link_ready), .link_data_o(link_data),
    .dac_sync_i(dac_sync), .dac_sync_in_i(dac_sync_in), .ext_sync_en_i(ext_sync_en),
    .sync_timeout_i(sync_timeout), .dac_enable_i(dac_enable), .dac_src_chan_sel_i(sel),
    .underflow_clr_i(underflow_clr), .sync_armed_o(sync_armed),
    .sync_timeout_err_o(sync_timeout_err), .underflow_count_o(underflow_count),
    .fifo_level_o(fifo_level)
  );

  function automatic logic [DW-1:0] mkBeat(input int k);
    logic [DW-1:0] b;
    b = '0;
    for (int c = 0; c < NCH; c++) b[CW*c +: CW] = 64'(k * 256 + c);
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic rdy);
    s_valid    = v;
    s_data     = d;
    link_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic waitFirstBeat();
    for (int n = 0; n < 10 && link_data == '0; n++) applyStimulus(1'b0, '0, 1'b1);
  endtask

  initial begin
    int q[$];
    logic [DW-1:0] expData, xbExp;
    int expUf, armedCnt;
    logic lr;

    reset = 1'b1; s_valid = 1'b0; s_data = '0; link_ready = 1'b1;
    dac_sync = 1'b0; dac_sync_in = 1'b0; ext_sync_en = 1'b0; sync_timeout = 16'd0;
    dac_enable = '1; sel = {8'd3, 8'd2, 8'd1, 8'd0}; underflow_clr = 1'b0;

    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rst_link_data", link_data, '0);
    checkOutput("rst_link_valid", link_valid, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_underflow", underflow_count, 0);
    checkOutput("rst_err", sync_timeout_err, 0);
    checkOutput("rst_armed", sync_armed, 0);
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_valid", link_valid, 1);
    checkOutput("post_rst_ready", s_ready, 1);

    $display("[TB] reset then stream");
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, mkBeat(k), 1'b1);
    checkOutput("idle_level", fifo_level, 8);
    checkOutput("idle_zero", link_data, '0);
    dac_sync = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    dac_sync = 1'b0;
    waitFirstBeat();
    checkOutput("stream_beat1", link_data, mkBeat(1));
    for (int k = 2; k <= 8; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("stream_beat%0d", k), link_data, mkBeat(k));
    end
    checkOutput("stream_uf", underflow_count, 0);
    checkOutput("stream_level", fifo_level, 0);

    $display("[TB] back-pressure");
    for (int k = 0; k < 16; k++) begin
      checkOutput("bp_fill_ready", s_ready, 1);
      applyStimulus(1'b1, mkBeat(101 + k), 1'b0);
      q.push_back(101 + k);
    end
    checkOutput("bp_full_level", fifo_level, 16);
    checkOutput("bp_full_ready", s_ready, 0);
    checkOutput("bp_hold", link_data, mkBeat(8));
    expData = mkBeat(8);
    expUf = 0;
    for (int i = 0; i < 40; i++) begin
      lr = ((i % 4) == 0) || ((i % 4) == 3);
      if (lr) begin
        if (q.size() > 0) begin
          if (i == 0 && q.size() < 16) q.push_back(117);
          expData = mkBeat(q.pop_front());
        end else begin
          expData = '0;
          expUf++;
        end
      end
      applyStimulus(i == 0, mkBeat(117), lr);
      checkOutput($sformatf("bp_data_%0d", i), link_data, expData);
      checkOutput($sformatf("bp_level_%0d", i), fifo_level, q.size());
      checkOutput($sformatf("bp_ready_%0d", i), s_ready, q.size() < 16);
    end
    checkOutput("bp_uf", underflow_count, expUf);
    underflow_clr = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    underflow_clr = 1'b0;
    checkOutput("bp_uf_clr", underflow_count, 0);

    $display("[TB] underflow");
    repeat (10) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("uf_zero_data", link_data, '0);
    checkOutput("uf_count10", underflow_count, 10);
    underflow_clr = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    underflow_clr = 1'b0;
    checkOutput("uf_clr_wins", underflow_count, 0);
    repeat (65534) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("uf_fffe", underflow_count, 16'hFFFE);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("uf_ffff", underflow_count, 16'hFFFF);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("uf_sat", underflow_count, 16'hFFFF);

    $display("[TB] crossbar");
    sel = {8'd1, 8'd9, 8'd3, 8'd0};
    dac_enable = 4'b1011;
    applyStimulus(1'b1, mkBeat(200), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    xbExp = '0;
    xbExp[0 +: 64]   = 64'd51200;
    xbExp[64 +: 64]  = 64'd51203;
    xbExp[192 +: 64] = 64'd51201;
    checkOutput("xbar_map", link_data, xbExp);
    sel = {8'd3, 8'd2, 8'd1, 8'd0};
    dac_enable = 4'b0110;
    applyStimulus(1'b1, mkBeat(201), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    xbExp = '0;
    xbExp[64 +: 64]  = 64'd51457;
    xbExp[128 +: 64] = 64'd51458;
    checkOutput("xbar_enable", link_data, xbExp);
    dac_enable = '1;

    $display("[TB] external sync timeout");
    ext_sync_en = 1'b1;
    sync_timeout = 16'd100;
    dac_sync = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    dac_sync = 1'b0;
    armedCnt = 0;
    for (int n = 0; n < 300; n++) begin
      if (sync_armed) armedCnt++;
      else if (armedCnt > 0) break;
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("to_armed_cycles", armedCnt, 100);
    checkOutput("to_err", sync_timeout_err, 1);
    checkOutput("to_idle", sync_armed, 0);
    checkOutput("to_data_zero", link_data, '0);
    underflow_clr = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    underflow_clr = 1'b0;
    checkOutput("to_err_clr", sync_timeout_err, 0);

    $display("[TB] external trigger");
    for (int k = 31; k <= 34; k++) applyStimulus(1'b1, mkBeat(k), 1'b1);
    dac_sync = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    dac_sync = 1'b0;
    repeat (49) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("trig_armed", sync_armed, 1);
    dac_sync_in = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    dac_sync_in = 1'b0;
    waitFirstBeat();
    checkOutput("trig_beat31", link_data, mkBeat(31));
    checkOutput("trig_err", sync_timeout_err, 0);
    checkOutput("trig_not_armed", sync_armed, 0);
    for (int k = 32; k <= 34; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("trig_beat%0d", k), link_data, mkBeat(k));
    end

    $display("[TB] simultaneous sync and trigger");
    dac_sync = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    dac_sync = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("simul_pre_armed", sync_armed, 1);
    dac_sync = 1'b1;
    dac_sync_in = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    dac_sync = 1'b0;
    dac_sync_in = 1'b0;
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("simul_armed", sync_armed, 1);

    $display("[TB] reset mid-run");
    ext_sync_en = 1'b0;
    sync_timeout = 16'd0;
    dac_sync = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    dac_sync = 1'b0;
    for (int k = 41; k <= 47; k++) applyStimulus(1'b1, mkBeat(k), 1'b0);
    checkOutput("mid_level7", fifo_level, 7);
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_rst_level", fifo_level, 0);
    checkOutput("mid_rst_data", link_data, '0);
    checkOutput("mid_rst_armed", sync_armed, 0);
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    for (int k = 51; k <= 54; k++) applyStimulus(1'b1, mkBeat(k), 1'b1);
    checkOutput("mid_idle_level", fifo_level, 4);
    checkOutput("mid_idle_data", link_data, '0);
    dac_sync = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    dac_sync = 1'b0;
    waitFirstBeat();
    checkOutput("mid_restart_beat51", link_data, mkBeat(51));
    for (int k = 52; k <= 54; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("mid_restart_beat%0d", k), link_data, mkBeat(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
